// File: rtl/UART_MIKE_pkg.sv
// Shared UART definitions: data/frame widths, the tx FSM state type and a width clamp helper.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit after the data bits).
package UART_MIKE_pkg;

    localparam int UART_DATA_WIDTH = 8;
    // Wide enough to hold the value UART_DATA_WIDTH itself.
    localparam int UART_FRAME_SIZE = $clog2(UART_DATA_WIDTH + 1);
    localparam int UART_MIN_WIDTH  = 5;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;
`endif

    // Forces a requested data width into the supported 5..UART_DATA_WIDTH range.
    function automatic logic [UART_FRAME_SIZE-1:0] clamp_width(
        input logic [UART_FRAME_SIZE-1:0] w
    );
        logic [UART_FRAME_SIZE-1:0] r;
        r = w;
        if (w < UART_FRAME_SIZE'(UART_MIN_WIDTH)) begin
            r = UART_FRAME_SIZE'(UART_MIN_WIDTH);
        end else if (w > UART_FRAME_SIZE'(UART_DATA_WIDTH)) begin
            r = UART_FRAME_SIZE'(UART_DATA_WIDTH);
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_serializer_if.sv
// Byte-in / serial-out handshake bundle for tx_serializer.
// master = byte producer, slave = serializer.
interface tx_serializer_if;
    import UART_MIKE_pkg::*;

    logic                       tx_valid;
    logic [UART_DATA_WIDTH-1:0] tx_data;
    logic [UART_FRAME_SIZE-1:0] uart_data_width;
    logic                       tx_ready;
    logic                       tx;
    logic                       tx_busy;
    logic                       tx_done;

    modport master (
        output tx_valid, tx_data, uart_data_width,
        input  tx_ready, tx, tx_busy, tx_done
    );

    modport slave (
        input  tx_valid, tx_data, uart_data_width,
        output tx_ready, tx, tx_busy, tx_done
    );
endinterface

// File: rtl/tx_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and strobes o_bit_end on the last cycle
// of each bit. o_bit_pre_end fires one cycle earlier so the FSM can register outputs
// that must be valid during the final cycle. i_reload holds the count at zero.
module tx_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_reload,
    output logic o_bit_end,
    output logic o_bit_pre_end
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_bit_end;

    assign w_bit_end     = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign o_bit_end     = w_bit_end;
    assign o_bit_pre_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 2));

    // Count cycles within a bit; restart at every bit boundary or on reload request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_reload || w_bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/tx_serializer.sv
// UART transmitter: accepts a byte on a valid/ready handshake and shifts it out as
// start bit, W data bits (LSB first), optional even parity, one stop bit.
// Optional feature macro: UART_TX_PARITY_EN.
module tx_serializer
    import UART_MIKE_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    tx_serializer_if.slave    bus
);
    tx_state_t                  r_state;
    logic [UART_DATA_WIDTH-1:0] r_data;
    logic [UART_FRAME_SIZE-1:0] r_width;
    logic [UART_FRAME_SIZE-1:0] r_bit_idx;
    logic                       r_tx;
    logic                       r_ready;
    logic                       r_busy;
    logic                       r_done;
`ifdef UART_TX_PARITY_EN
    logic                       r_parity;
`endif

    logic w_bit_end;
    logic w_bit_pre_end;
    logic w_reload;

    // The bit timer only runs while a frame is in flight.
    assign w_reload = (r_state == IDLE);

    tx_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk           (clk),
        .rst           (rst),
        .i_reload      (w_reload),
        .o_bit_end     (w_bit_end),
        .o_bit_pre_end (w_bit_pre_end)
    );

    assign bus.tx       = r_tx;
    assign bus.tx_ready = r_ready;
    assign bus.tx_busy  = r_busy;
    assign bus.tx_done  = r_done;

    // Frame FSM with registered line and status outputs; r_data shifts right as bits go out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_width   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking default; a later assignment in this block wins, and every
            // read below sees the pre-edge value, so ordering inside the case is irrelevant.
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.tx_valid) begin
                        r_data    <= bus.tx_data;
                        r_width   <= clamp_width(bus.uart_data_width);
                        r_bit_idx <= '0;
                        r_tx      <= 1'b0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= 1'b0;
`endif
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_tx     <= r_data[0];
                        r_data   <= {1'b0, r_data[UART_DATA_WIDTH-1:1]};
`ifdef UART_TX_PARITY_EN
                        r_parity <= r_parity ^ r_data[0];
`endif
                        r_state  <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == r_width - UART_FRAME_SIZE'(1)) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + UART_FRAME_SIZE'(1);
                            r_tx      <= r_data[0];
                            r_data    <= {1'b0, r_data[UART_DATA_WIDTH-1:1]};
`ifdef UART_TX_PARITY_EN
                            r_parity  <= r_parity ^ r_data[0];
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Raise done one cycle early so it is visible during the final stop cycle.
                    if (w_bit_pre_end) begin
                        r_done <= 1'b1;
                    end
                    if (w_bit_end) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tx_serializer.sv
// Self-checking bench for tx_serializer: directed frames plus randomized frames compared
// cycle by cycle against a frame model built from the line-format rules.
// Optional feature macro: UART_TX_PARITY_EN (the model follows the same define).
module tb_tx_serializer;
    import UART_MIKE_pkg::*;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    bit   exp_q[$];

    tx_serializer_if bus ();

    tx_serializer #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line levels, one entry per bit period: start, data LSB first, parity, stop.
    task automatic build_expected(input logic [7:0] d, input int w_req);
        int w;
        bit p;
        w = (w_req < 5) ? 5 : ((w_req > 8) ? 8 : w_req);
        exp_q.delete();
        exp_q.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < w; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (PAR) exp_q.push_back(p);
        exp_q.push_back(1'b1);
    endtask

    // Called at the negedge inside the first START cycle; checks every cycle of the frame.
    task automatic check_frame(input string name, input logic [7:0] d, input int w_req,
                               input bit scramble);
        int len;
        logic exp_done;
        build_expected(d, w_req);
        len = exp_q.size() * CPB;
        for (int k = 0; k < len; k++) begin
            n_tests++;
            if (bus.tx !== exp_q[k / CPB]) begin
                n_fail++;
                $display("FAIL %s tx cycle %0d: got %b expected %b", name, k, bus.tx, exp_q[k / CPB]);
            end
            exp_done = (k == len - 1);
            n_tests++;
            if (bus.tx_done !== exp_done) begin
                n_fail++;
                $display("FAIL %s tx_done cycle %0d: got %b expected %b", name, k, bus.tx_done, exp_done);
            end
            n_tests++;
            if (bus.tx_busy !== 1'b1 || bus.tx_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy/ready cycle %0d: got %b/%b expected 1/0",
                         name, k, bus.tx_busy, bus.tx_ready);
            end
            if (scramble && k == 3) begin
                bus.tx_data         = 8'($urandom);
                bus.uart_data_width = UART_FRAME_SIZE'($urandom);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string name);
        n_tests++;
        if (bus.tx !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle: got tx=%b ready=%b busy=%b done=%b expected 1 1 0 0",
                     name, bus.tx, bus.tx_ready, bus.tx_busy, bus.tx_done);
        end
    endtask

    // Bounded wait for the serializer to accept; call at a negedge.
    task automatic wait_ready(input string name);
        int i;
        i = 0;
        while (bus.tx_ready !== 1'b1 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        n_tests++;
        if (bus.tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready timeout: got %b expected 1", name, bus.tx_ready);
        end
    endtask

    task automatic do_frame(input string name, input logic [7:0] d, input int w_req);
        wait_ready(name);
        bus.tx_valid        = 1'b1;
        bus.tx_data         = d;
        bus.uart_data_width = UART_FRAME_SIZE'(w_req);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check_frame(name, d, w_req, 1'b1);
        check_idle(name);
    endtask

    task automatic test_reset;
        n_tests++;
        if (bus.tx !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got tx=%b ready=%b busy=%b done=%b expected 1 1 0 0",
                     bus.tx, bus.tx_ready, bus.tx_busy, bus.tx_done);
        end
    endtask

    task automatic test_basic;
        do_frame("a5_w8", 8'hA5, 8);
        do_frame("w3_clamp", 8'h00, 3);
        do_frame("w15_clamp", 8'h3C, 15);
        do_frame("w5_ff", 8'hFF, 5);
        do_frame("w6_mixed", 8'h2D, 6);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        do_frame("par_w5_ff", 8'hFF, 5);
        do_frame("par_w8_01", 8'h01, 8);
        do_frame("par_w7_00", 8'h00, 7);
    endtask
`endif

    task automatic test_random;
        for (int i = 0; i < 20; i++) begin
            do_frame("random", 8'($urandom), int'($urandom_range(0, 15)));
        end
    endtask

    task automatic test_back_to_back;
        wait_ready("b2b");
        bus.tx_valid        = 1'b1;
        bus.tx_data         = 8'h55;
        bus.uart_data_width = UART_FRAME_SIZE'(8);
        @(negedge clk);
        // Valid stays high; the new byte must not leak into frame 1.
        bus.tx_data = 8'h0F;
        check_frame("b2b_f1", 8'h55, 8, 1'b0);
        check_idle("b2b_gap");
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check_frame("b2b_f2", 8'h0F, 8, 1'b0);
        check_idle("b2b_end");
    endtask

    task automatic test_reset_mid_frame;
        bit bad;
        wait_ready("rst_mid");
        bus.tx_valid        = 1'b1;
        bus.tx_data         = 8'hF0;
        bus.uart_data_width = UART_FRAME_SIZE'(8);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        // Move into the middle of data bit 3 (bit value 0 for 0xF0).
        repeat (CPB * 4 + 5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.tx !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid immediate: got tx=%b ready=%b busy=%b done=%b expected 1 1 0 0",
                     bus.tx, bus.tx_ready, bus.tx_busy, bus.tx_done);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (bus.tx_done !== 1'b0 || bus.tx !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL rst_mid quiet: got activity after reset expected idle line, no tx_done");
        end
        do_frame("rst_mid_after", 8'hC3, 8);
    endtask

    initial begin
        n_tests             = 0;
        n_fail              = 0;
        rst                 = 1'b1;
        bus.tx_valid        = 1'b0;
        bus.tx_data         = '0;
        bus.uart_data_width = '0;
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_basic;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        test_back_to_back;
        test_random;
        test_reset_mid_frame;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
